// File: rtl/udp_reg_bridge_pkg.sv
// Shared constants, FSM state type and beat pack/unpack helpers for udp_reg_bridge.
// Optional command counter at 0xFFFF is enabled by defining UDP_REG_BRIDGE_CNT_EN.
package udp_reg_bridge_pkg;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_OP   = 8'h01;
    localparam logic [7:0] ST_BAD_ADDR = 8'h02;

    localparam logic [15:0] CNT_ADDR = 16'hFFFF;

    // Byte offsets within a 64-bit beat; byte 0 is tdata[7:0].
    localparam int OFS_OP     = 0;
    localparam int OFS_STATUS = 1;
    localparam int OFS_ADDR   = 2;
    localparam int OFS_DATA   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_DROP,
        S_TX_HDR,
        S_TX_PAY
    } state_t;

    function automatic logic [15:0] get_addr(input logic [63:0] beat);
        return {beat[OFS_ADDR*8 +: 8], beat[(OFS_ADDR+1)*8 +: 8]};
    endfunction

    function automatic logic [31:0] get_data(input logic [63:0] beat);
        return {beat[OFS_DATA*8 +: 8], beat[(OFS_DATA+1)*8 +: 8],
                beat[(OFS_DATA+2)*8 +: 8], beat[(OFS_DATA+3)*8 +: 8]};
    endfunction

    function automatic logic [63:0] pack_rsp(input logic [7:0] op, input logic [7:0] status,
                                             input logic [15:0] addr, input logic [31:0] data);
        logic [63:0] beat;
        beat = '0;
        beat[OFS_OP*8 +: 8]       = op;
        beat[OFS_STATUS*8 +: 8]   = status;
        beat[OFS_ADDR*8 +: 8]     = addr[15:8];
        beat[(OFS_ADDR+1)*8 +: 8] = addr[7:0];
        for (int i = 0; i < 4; i++) begin
            beat[(OFS_DATA+i)*8 +: 8] = data[31-8*i -: 8];
        end
        return beat;
    endfunction

endpackage

// File: rtl/udp_reg_bridge_if.sv
// UDP frame bundle: header handshake and fields plus the 64-bit payload stream.
// Valid/ready: a header or beat transfers on a rising edge where valid and ready are both high; valid holds its fields until then.
interface udp_reg_bridge_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [5:0]  ip_dscp;
    logic [1:0]  ip_ecn;
    logic [7:0]  ip_ttl;
    logic [31:0] ip_source_ip;
    logic [31:0] ip_dest_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] length;
    logic [15:0] checksum;
    logic [63:0] payload_axis_tdata;
    logic [7:0]  payload_axis_tkeep;
    logic        payload_axis_tvalid;
    logic        payload_axis_tready;
    logic        payload_axis_tlast;
    logic        payload_axis_tuser;

    modport master (
        output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
               source_port, dest_port, length, checksum,
               payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
               payload_axis_tlast, payload_axis_tuser,
        input  hdr_ready, payload_axis_tready
    );

    modport slave (
        input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
               source_port, dest_port, length, checksum,
               payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
               payload_axis_tlast, payload_axis_tuser,
        output hdr_ready, payload_axis_tready
    );
endinterface

// File: rtl/udp_reg_bridge_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count and synchronous flush.
// DEPTH must be a power of two so the pointers wrap on their own.
module udp_reg_bridge_rsp_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/udp_reg_bridge.sv
// UDP register-access endpoint: executes 8-byte read/write commands, replies with one frame per request.
// Define UDP_REG_BRIDGE_CNT_EN to expose a read-only executed-command counter at address 0xFFFF.
module udp_reg_bridge
    import udp_reg_bridge_pkg::*;
#(
    parameter int PORT      = 1234,
    parameter int REG_COUNT = 16,
    parameter int MAX_CMDS  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            local_ip,
    udp_reg_bridge_if.slave        s_udp,
    udp_reg_bridge_if.master       m_udp,
    output logic [REG_COUNT*32-1:0] regs_flat,
    output state_t                 dbg_state_o
);
    localparam int CW  = $clog2(MAX_CMDS) + 1;
    localparam int RAW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    state_t         state_q, state_d;
    logic [31:0]    peer_ip_q, peer_ip_d;
    logic [15:0]    peer_port_q, peer_port_d;
    logic [31:0]    regs_q [REG_COUNT];

    logic [7:0]     cmd_op;
    logic [15:0]    cmd_addr;
    logic [31:0]    cmd_data;
    logic [RAW-1:0] reg_idx;
    logic [7:0]     rsp_status;
    logic [31:0]    rsp_data;
    logic           exec, wr_en, write_ok;

    logic           hdr_ready, rx_ready, pop, flush;
    logic           tx_hdr, tx_pay;
    logic [63:0]    fifo_head;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full, fifo_empty;

    assign cmd_op   = s_udp.payload_axis_tdata[OFS_OP*8 +: 8];
    assign cmd_addr = get_addr(s_udp.payload_axis_tdata);
    assign cmd_data = get_data(s_udp.payload_axis_tdata);
    assign reg_idx  = cmd_addr[RAW-1:0];

    // Only full beats execute, and only while there is room to hold their response.
    assign exec = (state_q == S_RX) && s_udp.payload_axis_tvalid &&
                  (s_udp.payload_axis_tkeep == 8'hFF) && !fifo_full;

`ifdef UDP_REG_BRIDGE_CNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst)       cnt_q <= '0;
        else if (exec) cnt_q <= cnt_q + 32'd1;
    end
`endif

    always_comb begin
        rsp_status = ST_OK;
        rsp_data   = '0;
        write_ok   = 1'b0;
        if (cmd_op != OP_READ && cmd_op != OP_WRITE) begin
            rsp_status = ST_BAD_OP;
`ifdef UDP_REG_BRIDGE_CNT_EN
        end else if (cmd_addr == CNT_ADDR) begin
            if (cmd_op == OP_READ) rsp_data = cnt_q;
            else                   rsp_status = ST_BAD_ADDR;
`endif
        end else if ({16'd0, cmd_addr} >= 32'(REG_COUNT)) begin
            rsp_status = ST_BAD_ADDR;
        end else if (cmd_op == OP_READ) begin
            rsp_data = regs_q[reg_idx];
        end else begin
            rsp_data = cmd_data;
            write_ok = 1'b1;
        end
    end

    assign wr_en = exec && write_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[reg_idx] <= cmd_data;
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
        assign regs_flat[g*32 +: 32] = regs_q[g];
    end

    udp_reg_bridge_rsp_fifo #(.DEPTH(MAX_CMDS), .WIDTH(64)) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (exec),
        .data_i  (pack_rsp(cmd_op, rsp_status, cmd_addr, rsp_data)),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        peer_ip_d   = peer_ip_q;
        peer_port_d = peer_port_q;
        hdr_ready   = 1'b0;
        rx_ready    = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        case (state_q)
            S_IDLE: begin
                hdr_ready = !rst;
                if (s_udp.hdr_valid && !rst) begin
                    peer_ip_d   = s_udp.ip_source_ip;
                    peer_port_d = s_udp.source_port;
                    state_d     = (s_udp.dest_port == 16'(PORT)) ? S_RX : S_DROP;
                end
            end
            S_RX: begin
                rx_ready = 1'b1;
                if (s_udp.payload_axis_tvalid && s_udp.payload_axis_tlast) begin
                    // A tuser-flagged frame keeps its register writes but gets no reply.
                    if ((fifo_empty && !exec) || s_udp.payload_axis_tuser) begin
                        flush   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_TX_HDR;
                    end
                end
            end
            S_DROP: begin
                rx_ready = 1'b1;
                if (s_udp.payload_axis_tvalid && s_udp.payload_axis_tlast) state_d = S_IDLE;
            end
            S_TX_HDR: begin
                if (m_udp.hdr_ready) state_d = S_TX_PAY;
            end
            S_TX_PAY: begin
                pop = m_udp.payload_axis_tready;
                if (m_udp.payload_axis_tready && fifo_count == CW'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            peer_ip_q   <= '0;
            peer_port_q <= '0;
        end else begin
            state_q     <= state_d;
            peer_ip_q   <= peer_ip_d;
            peer_port_q <= peer_port_d;
        end
    end

    assign tx_hdr = (state_q == S_TX_HDR);
    assign tx_pay = (state_q == S_TX_PAY);

    assign s_udp.hdr_ready           = hdr_ready;
    assign s_udp.payload_axis_tready = rx_ready;

    assign m_udp.hdr_valid    = tx_hdr;
    assign m_udp.ip_dscp      = '0;
    assign m_udp.ip_ecn       = '0;
    assign m_udp.ip_ttl       = tx_hdr ? 8'd64 : 8'd0;
    assign m_udp.ip_source_ip = tx_hdr ? local_ip : '0;
    assign m_udp.ip_dest_ip   = tx_hdr ? peer_ip_q : '0;
    assign m_udp.source_port  = tx_hdr ? 16'(PORT) : '0;
    assign m_udp.dest_port    = tx_hdr ? peer_port_q : '0;
    assign m_udp.length       = tx_hdr ? 16'(8 + 8 * int'(fifo_count)) : '0;
    assign m_udp.checksum     = '0;

    assign m_udp.payload_axis_tdata  = tx_pay ? fifo_head : '0;
    assign m_udp.payload_axis_tkeep  = tx_pay ? 8'hFF : 8'h00;
    assign m_udp.payload_axis_tvalid = tx_pay;
    assign m_udp.payload_axis_tlast  = tx_pay && (fifo_count == CW'(1));
    assign m_udp.payload_axis_tuser  = 1'b0;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_udp_reg_bridge.sv
// Directed bench for udp_reg_bridge: hand-computed command/response beats and header fields.
// Builds with or without UDP_REG_BRIDGE_CNT_EN; the 0xFFFF read expectation follows the macro.
module tb_udp_reg_bridge;
    import udp_reg_bridge_pkg::*;

    localparam int          PORT      = 1234;
    localparam int          REG_COUNT = 16;
    localparam int          MAX_CMDS  = 32;
    localparam logic [31:0] LOCAL_IP  = 32'hC0A80001;
    localparam logic [31:0] PEER_IP   = 32'hC0A80064;
    localparam logic [15:0] PEER_PORT = 16'd40000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic [31:0] local_ip;
    logic [REG_COUNT*32-1:0] regs_flat;
    state_t dbg_state;

    always #5 clk = ~clk;

    udp_reg_bridge_if rx_if ();
    udp_reg_bridge_if tx_if ();

    udp_reg_bridge #(.PORT(PORT), .REG_COUNT(REG_COUNT), .MAX_CMDS(MAX_CMDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .local_ip    (local_ip),
        .s_udp       (rx_if),
        .m_udp       (tx_if),
        .regs_flat   (regs_flat),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int n);
        return regs_flat[n*32 +: 32];
    endfunction

    function automatic logic [63:0] beat_of(input logic [7:0] op, input logic [7:0] b1,
                                            input logic [15:0] addr, input logic [31:0] data);
        return {data[7:0], data[15:8], data[23:16], data[31:24], addr[7:0], addr[15:8], b1, op};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_hdr(input logic [15:0] dport);
        int n = 0;
        rx_if.hdr_valid    = 1'b1;
        rx_if.ip_source_ip = PEER_IP;
        rx_if.source_port  = PEER_PORT;
        rx_if.dest_port    = dport;
        do begin @(negedge clk); n++; end while (!rx_if.hdr_ready && n < 50);
        chk("rx_hdr_ready", rx_if.hdr_ready, 1);
        @(posedge clk); #1;
        rx_if.hdr_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [7:0] keep,
                             input logic last, input logic user);
        int n = 0;
        rx_if.payload_axis_tdata  = data;
        rx_if.payload_axis_tkeep  = keep;
        rx_if.payload_axis_tlast  = last;
        rx_if.payload_axis_tuser  = user;
        rx_if.payload_axis_tvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!rx_if.payload_axis_tready && n < 50);
        chk("rx_tready", rx_if.payload_axis_tready, 1);
        @(posedge clk); #1;
        rx_if.payload_axis_tvalid = 1'b0;
        rx_if.payload_axis_tlast  = 1'b0;
        rx_if.payload_axis_tuser  = 1'b0;
    endtask

    task automatic recv_reply(input logic [15:0] exp_len, input bit toggle);
        int n = 0;
        logic [63:0] e;
        do begin @(negedge clk); n++; end while (!tx_if.hdr_valid && n < 50);
        chk("hdr_valid", tx_if.hdr_valid, 1);
        chk("hdr_length", tx_if.length, exp_len);
        chk("hdr_src_port", tx_if.source_port, PORT);
        chk("hdr_dst_port", tx_if.dest_port, PEER_PORT);
        chk("hdr_dst_ip", tx_if.ip_dest_ip, PEER_IP);
        chk("hdr_src_ip", tx_if.ip_source_ip, LOCAL_IP);
        chk("hdr_ttl", tx_if.ip_ttl, 64);
        chk("hdr_dscp_ecn_csum", {tx_if.ip_dscp, tx_if.ip_ecn, tx_if.checksum}, 0);
        @(posedge clk); #1;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tx_if.payload_axis_tready = toggle ? (n % 2 == 0) : 1'b1;
            @(negedge clk);
            if (!tx_if.payload_axis_tready) begin
                chk("pay_valid_held", tx_if.payload_axis_tvalid, 1);
            end else if (tx_if.payload_axis_tvalid) begin
                e = exp_q.pop_front();
                chk("pay_data", tx_if.payload_axis_tdata, e);
                chk("pay_last", tx_if.payload_axis_tlast, exp_q.size() == 0);
                chk("pay_keep_user", {tx_if.payload_axis_tkeep, tx_if.payload_axis_tuser}, 9'h1FE);
            end
            @(posedge clk); #1;
            n++;
        end
        tx_if.payload_axis_tready = 1'b0;
        chk("rsp_remaining", exp_q.size(), 0);
        @(negedge clk);
        chk("back_to_idle", dbg_state, S_IDLE);
        @(posedge clk); #1;
    endtask

    task automatic expect_no_reply();
        logic seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= tx_if.hdr_valid;
        end
        chk("no_reply", seen, 0);
        chk("idle_after_drop", dbg_state, S_IDLE);
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst                       = 1'b1;
        local_ip                  = LOCAL_IP;
        rx_if.hdr_valid           = 1'b0;
        rx_if.ip_dscp             = '0;
        rx_if.ip_ecn              = '0;
        rx_if.ip_ttl              = '0;
        rx_if.ip_source_ip        = '0;
        rx_if.ip_dest_ip          = '0;
        rx_if.source_port         = '0;
        rx_if.dest_port           = '0;
        rx_if.length              = '0;
        rx_if.checksum            = '0;
        rx_if.payload_axis_tdata  = '0;
        rx_if.payload_axis_tkeep  = '0;
        rx_if.payload_axis_tvalid = 1'b0;
        rx_if.payload_axis_tlast  = 1'b0;
        rx_if.payload_axis_tuser  = 1'b0;
        tx_if.hdr_ready           = 1'b1;
        tx_if.payload_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_m_hdr_valid", tx_if.hdr_valid, 0);
        chk("rst_m_tvalid_tlast", {tx_if.payload_axis_tvalid, tx_if.payload_axis_tlast}, 0);
        chk("rst_s_tready", rx_if.payload_axis_tready, 0);
        chk("rst_hdr_fields", {tx_if.length, tx_if.dest_port, tx_if.ip_dest_ip, tx_if.ip_ttl}, 0);
        chk("rst_regs", regs_flat[63:0], 0);
        @(posedge clk); #1;

        // Single write 0x0003 = DEADBEEF
        send_hdr(16'(PORT));
        send_beat(64'hEFBEADDE_03000002, 8'hFF, 1'b1, 1'b0);
        exp_q.push_back(64'hEFBEADDE_03000002);
        recv_reply(16'd16, 1'b0);
        chk("t1_reg3", reg_of(3), 32'hDEADBEEF);

        // Write then read the same register in back-to-back beats
        send_hdr(16'(PORT));
        send_beat(64'h44332211_01000002, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h00000000_01000001, 8'hFF, 1'b1, 1'b0);
        exp_q.push_back(64'h44332211_01000002);
        exp_q.push_back(64'h44332211_01000001);
        recv_reply(16'd24, 1'b0);
        chk("t2_reg1", reg_of(1), 32'h11223344);

        // Frame to another port is drained without effect
        send_hdr(16'd5000);
        send_beat(64'h55000000_05000002, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h00000000_03000002, 8'hFF, 1'b1, 1'b0);
        expect_no_reply();
        chk("t3_reg5", reg_of(5), 32'h0);
        chk("t3_reg3", reg_of(3), 32'hDEADBEEF);

        // Bad address, partial beat (ignored), bad opcode
        send_hdr(16'(PORT));
        send_beat(64'h00000000_20000001, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h44444444_04000002, 8'h0F, 1'b0, 1'b0);
        send_beat(64'h78563412_02000007, 8'hFF, 1'b1, 1'b0);
        exp_q.push_back(64'h00000000_20000201);
        exp_q.push_back(64'h00000000_02000107);
        recv_reply(16'd24, 1'b0);
        chk("t4_reg4", reg_of(4), 32'h0);
        chk("t4_reg2", reg_of(2), 32'h0);

        // 40 writes: only the first 32 fit; reply drained with toggling ready
        send_hdr(16'(PORT));
        for (int i = 0; i < 40; i++) begin
            send_beat(beat_of(8'h02, 8'h00, 16'(i % 16), 32'hA5000000 + 32'(i)), 8'hFF,
                      i == 39, 1'b0);
            if (i < 32) exp_q.push_back(beat_of(8'h02, 8'h00, 16'(i % 16), 32'hA5000000 + 32'(i)));
        end
        recv_reply(16'd264, 1'b1);
        chk("t5_reg0", reg_of(0), 32'hA5000010);
        chk("t5_reg7", reg_of(7), 32'hA5000017);
        chk("t5_reg15", reg_of(15), 32'hA500001F);

        // tuser on the last beat suppresses the reply but keeps the write
        send_hdr(16'(PORT));
        send_beat(64'h99999999_09000002, 8'hFF, 1'b1, 1'b1);
        expect_no_reply();
        chk("t6_reg9", reg_of(9), 32'h99999999);

        // Counter read: 1 + 2 + 2 + 32 + 1 commands executed so far
        send_hdr(16'(PORT));
        send_beat(64'h00000000_FFFF0001, 8'hFF, 1'b1, 1'b0);
`ifdef UDP_REG_BRIDGE_CNT_EN
        exp_q.push_back(64'h26000000_FFFF0001);
`else
        exp_q.push_back(64'h00000000_FFFF0201);
`endif
        recv_reply(16'd16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/udp_reg_bridge.md
# udp_reg_bridge

UDP register-access endpoint sitting directly downstream of the UDP stack's receive UDP frame output and upstream of its transmit UDP frame input, on the 64-bit datapath in the `clk` domain. It accepts frames addressed to one UDP port and treats each 8-byte payload beat as a read or write command against an internal 32-bit register file. It returns one UDP reply frame per request frame, with one 8-byte response beat per executed command. Frames addressed to any other port are drained and dropped.

## Interface
Parameters:
- `PORT`, 1234: UDP destination port served.
- `REG_COUNT`, 16: number of 32-bit registers, 1..256.
- `MAX_CMDS`, 32: response buffer depth; must be a power of 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `local_ip` in 32: source IP placed in replies.
- `s_udp_hdr_valid` / `s_udp_hdr_ready` in / out 1: receive header handshake.
- `s_udp_ip_source_ip` in 32; `s_udp_source_port` in 16; `s_udp_dest_port` in 16: receive header fields.
- `s_udp_payload_axis_tdata` in 64; `_tkeep` in 8; `_tvalid` in 1; `_tready` out 1; `_tlast` in 1; `_tuser` in 1: receive payload stream.
- `m_udp_hdr_valid` / `m_udp_hdr_ready` out / in 1: transmit header handshake.
- `m_udp_ip_dscp` out 6; `_ecn` out 2; `_ttl` out 8; `_ip_source_ip` out 32; `_ip_dest_ip` out 32: transmit IP header fields.
- `m_udp_source_port` out 16; `_dest_port` out 16; `_length` out 16; `_checksum` out 16: transmit UDP header fields.
- `m_udp_payload_axis_tdata` out 64; `_tkeep` out 8; `_tvalid` out 1; `_tready` in 1; `_tlast` out 1; `_tuser` out 1: transmit payload stream.
- `regs_flat` out REG_COUNT*32: register file contents; register n occupies bits [32n+31:32n].

## Operation
- Command beat byte layout, in wire order: byte 0 is `tdata[7:0]`.
  - byte0: opcode. 0x01 is read, 0x02 is write.
  - byte1: reserved.
  - bytes2-3: address, big-endian.
  - bytes4-7: data, big-endian.
- Response beat: byte0 is the opcode echoed; byte1 is the status; bytes2-3 the address; bytes4-7 the data.
  - Read returns the register value.
  - Write returns the written value.
  - Error returns data 0.
- Status codes: 0x00 OK; 0x01 bad opcode; 0x02 address ≥ REG_COUNT.
- FSM states:
  - IDLE: `s_udp_hdr_ready`=1. On handshake, capture source IP and source port. Go to RX if `dest_port==PORT`, else DROP.
  - RX: `s_tready`=1. Per accepted beat with `tkeep==8'hFF` and buffer not full: execute the command and push the response. Beats with partial `tkeep`, or beats arriving while the buffer is full, are consumed with no execution and no response. On the `tlast` beat, go to TX_HDR; if the buffer is empty or `tuser`=1, flush the buffer and go to IDLE instead.
  - DROP: `s_tready`=1. Consume beats; `tlast` goes to IDLE.
  - TX_HDR: `m_udp_hdr_valid`=1; on handshake go to TX_PAY. Header fields:
    - source port = PORT; dest port = captured source port.
    - dest IP = captured IP; source IP = `local_ip`.
    - length = 8 + 8*N, where N is the buffered response count.
    - ttl 64; dscp, ecn and checksum 0.
  - TX_PAY: stream N beats from the buffer with `tkeep`=FF and `tuser`=0; `tlast` on beat N; return to IDLE.
- A write takes effect even if the frame is later dropped for `tuser`; only the reply is suppressed.

## Timing
- Reset: FSM in IDLE; all registers 0; buffer empty; every output valid, ready and `tlast` 0; header field outputs 0.
- Register write visible on `regs_flat` one cycle after the beat's handshake.
- Throughput: RX accepts one beat per cycle; responses are written combinationally from the beat, with no stall.
- `m_udp_hdr_valid` asserts the cycle after the `tlast` handshake. Header fields are stable while valid is high.
- TX_PAY: `m_tvalid` is continuous, so N beats take N cycles under constant ready. Output is held while `m_tready`=0.
- A read and a write to the same register in consecutive beats: the read returns the newly written value.
- A new request is not accepted until the reply completes.
- `rst` asserted mid-frame returns to the reset state; remaining input beats are later consumed in IDLE only through a fresh header.

## Configuration
- `UDP_REG_BRIDGE_CNT_EN`:
  - Defined: address 0xFFFF is a read-only 32-bit wrapping counter of executed commands, incremented per OK or error response and cleared by `rst`. Writing to 0xFFFF returns status 0x02.
  - Undefined: 0xFFFF is out of range like any other address.

## Structure
- Package `udp_reg_bridge_pkg`:
  - opcode constants;
  - status constants;
  - counter address 0xFFFF;
  - FSM state enum;
  - command/response beat field offsets.
- Sub-module `udp_reg_bridge_rsp_fifo`: synchronous 64-bit FIFO of depth MAX_CMDS with count output and flush input.

## Test plan
- Frame to port 1234 with one beat (write 0x0003 = 0xDEADBEEF) → reg3=DEADBEEF; reply length 16, status 0, data DEADBEEF, ports swapped.
- Write 0x0001=0x11223344 then read 0x0001 in one frame → reply length 24; second beat returns 0x11223344.
- Frame to port 5000 → all beats consumed; no `m_udp_hdr_valid`; registers unchanged.
- Read 0x0020 and opcode 0x07 → statuses 0x02 and 0x01, data 0.
- 40-beat frame with MAX_CMDS=32 → 32 executed; length 264; `m_tready` toggled every other cycle without data loss.
- Frame with `tuser`=1 on `tlast` → no reply; the write is applied; with CNT_EN, a read of 0xFFFF reflects the count.
